// File: rtl/cannon_sequencer.sv
// rtl/cannon_sequencer.sv - Cannon block-matrix multiplier control sequencer
// Walks the PE grid through load, optional skew, SQRT_P MAC/shift rounds and drain.
module cannon_sequencer #(
  parameter int SQRT_P    = 2,
  parameter int MAC_LAT   = 4,
  parameter int DRAIN_LAT = 2,
  localparam int IDXW     = (SQRT_P > 1) ? $clog2(SQRT_P) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            preskewed,
  input  logic            abort,
  input  logic            shift_ack,
  output logic            load_en,
  output logic            acc_clr,
  output logic            skew_en,
  output logic [IDXW-1:0] skew_idx,
  output logic            mac_en,
  output logic            shift_en,
  output logic            drain_en,
  output logic [IDXW-1:0] step,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  output logic [2:0]      state
);

  localparam int MW = $clog2(MAC_LAT + 1);
  localparam int DW = (DRAIN_LAT > 0) ? $clog2(DRAIN_LAT + 1) : 1;

  localparam logic [IDXW-1:0] SKEW_LAST  = IDXW'((SQRT_P > 1) ? SQRT_P - 2 : 0);
  localparam logic [IDXW-1:0] STEP_LAST  = IDXW'(SQRT_P - 1);
  localparam logic [MW-1:0]   MAC_LAST   = MW'(MAC_LAT - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'((DRAIN_LAT > 0) ? DRAIN_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SKEW  = 3'd2,
    S_MAC   = 3'd3,
    S_SHIFT = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            pre_q;
  logic            out_valid_q;
  logic [IDXW-1:0] skew_q;
  logic [IDXW-1:0] step_q;
  logic [MW-1:0]   mac_q;
  logic [DW-1:0]   drain_q;
  logic            kill;

  assign kill = abort && (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_LOAD;
        S_LOAD:  state_d = (!pre_q && SQRT_P > 1) ? S_SKEW : S_MAC;
        S_SKEW:  if (skew_q == SKEW_LAST) state_d = S_MAC;
        S_MAC: begin
          if (mac_q == MAC_LAST) begin
            if (step_q != STEP_LAST)  state_d = S_SHIFT;
            else if (DRAIN_LAT == 0)  state_d = S_DONE;
            else                      state_d = S_DRAIN;
          end
        end
        S_SHIFT: if (shift_ack) state_d = S_MAC;
        S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A run reaching DONE counts as complete even if abort arrives in that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q       <= 1'b0;
      out_valid_q <= 1'b0;
      skew_q      <= '0;
      step_q      <= '0;
      mac_q       <= '0;
      drain_q     <= '0;
    end else begin
      if (state_q == S_DONE)                out_valid_q <= 1'b1;
      else if (state_q == S_IDLE && start)  out_valid_q <= 1'b0;
      if (state_q == S_IDLE && start) pre_q <= preskewed;
      if (kill) begin
        skew_q  <= '0;
        step_q  <= '0;
        mac_q   <= '0;
        drain_q <= '0;
      end else begin
        skew_q  <= (state_q == S_SKEW  && skew_q  != SKEW_LAST)  ? skew_q + 1'b1  : '0;
        mac_q   <= (state_q == S_MAC   && mac_q   != MAC_LAST)   ? mac_q + 1'b1   : '0;
        drain_q <= (state_q == S_DRAIN && drain_q != DRAIN_LAST) ? drain_q + 1'b1 : '0;
        if (state_q == S_LOAD)                    step_q <= '0;
        else if (state_q == S_SHIFT && shift_ack) step_q <= step_q + 1'b1;
      end
    end
  end

  always_comb begin
    load_en  = 1'b0;
    acc_clr  = 1'b0;
    skew_en  = 1'b0;
    mac_en   = 1'b0;
    shift_en = 1'b0;
    drain_en = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        load_en = 1'b1;
        acc_clr = 1'b1;
      end
      S_SKEW:  skew_en  = 1'b1;
      S_MAC:   mac_en   = 1'b1;
      S_SHIFT: shift_en = 1'b1;
      S_DRAIN: drain_en = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  assign skew_idx  = skew_q;
  assign step      = step_q;
  assign out_valid = out_valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cannon_sequencer.sv
// tb/tb_cannon_sequencer.sv - scoreboard bench for cannon_sequencer
// Three instances: defaults, 4x4 grid with slow shift ack, 1x1 grid without drain.
module tb_cannon_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start0, pre0, abort0, ack0;
  logic ld0, ac0, sk0, mc0, sh0, dr0, bsy0, dn0, ov0;
  logic [0:0] sidx0, stp0;
  logic [2:0] st0;

  logic start1, pre1, abort1, ack1;
  logic ld1, ac1, sk1, mc1, sh1, dr1, bsy1, dn1, ov1;
  logic [1:0] sidx1, stp1;
  logic [2:0] st1;

  logic start2, pre2, abort2, ack2;
  logic ld2, ac2, sk2, mc2, sh2, dr2, bsy2, dn2, ov2;
  logic [0:0] sidx2, stp2;
  logic [2:0] st2;

  cannon_sequencer u0 (
    .clk(clk), .reset(rst), .start(start0), .preskewed(pre0), .abort(abort0), .shift_ack(ack0),
    .load_en(ld0), .acc_clr(ac0), .skew_en(sk0), .skew_idx(sidx0), .mac_en(mc0), .shift_en(sh0),
    .drain_en(dr0), .step(stp0), .busy(bsy0), .done(dn0), .out_valid(ov0), .state(st0));

  cannon_sequencer #(.SQRT_P(4), .MAC_LAT(3), .DRAIN_LAT(2)) u1 (
    .clk(clk), .reset(rst), .start(start1), .preskewed(pre1), .abort(abort1), .shift_ack(ack1),
    .load_en(ld1), .acc_clr(ac1), .skew_en(sk1), .skew_idx(sidx1), .mac_en(mc1), .shift_en(sh1),
    .drain_en(dr1), .step(stp1), .busy(bsy1), .done(dn1), .out_valid(ov1), .state(st1));

  cannon_sequencer #(.SQRT_P(1), .MAC_LAT(4), .DRAIN_LAT(0)) u2 (
    .clk(clk), .reset(rst), .start(start2), .preskewed(pre2), .abort(abort2), .shift_ack(ack2),
    .load_en(ld2), .acc_clr(ac2), .skew_en(sk2), .skew_idx(sidx2), .mac_en(mc2), .shift_en(sh2),
    .drain_en(dr2), .step(stp2), .busy(bsy2), .done(dn2), .out_valid(ov2), .state(st2));

  int errors = 0;
  int checks = 0;
  int q0[$], q1[$], q2[$];
  int base [3];
  logic mon_en = 1'b0;

  // Grid model for u1: acknowledges on the third cycle of each shift request.
  int wcnt1 = 0;
  always @(negedge clk) begin
    if (sh1) begin
      if (wcnt1 == 2) begin ack1 = 1'b1; wcnt1 = 0; end
      else begin ack1 = 1'b0; wcnt1 = wcnt1 + 1; end
    end else begin
      ack1 = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Event codes: 1 load, 2 skew, 3 mac, 4 shift, 5 drain, 6 done.
  function automatic int enc(input int c, input int code, input int idx);
    return c * 64 + code * 8 + idx;
  endfunction

  task automatic push(input int inst, input int c, input int code, input int idx);
    case (inst)
      0:       q0.push_back(enc(c, code, idx));
      1:       q1.push_back(enc(c, code, idx));
      default: q2.push_back(enc(c, code, idx));
    endcase
  endtask

  task automatic push_run(input int inst, input int p, input int skew, input int mac,
                          input int wait_c, input int drain);
    int c;
    c = 1;
    push(inst, c, 1, 0); c = c + 1;
    if (skew != 0)
      for (int i = 0; i < p - 1; i++) begin push(inst, c, 2, i); c = c + 1; end
    for (int r = 0; r < p; r++) begin
      for (int m = 0; m < mac; m++) begin push(inst, c, 3, r); c = c + 1; end
      if (r < p - 1)
        for (int w = 0; w < wait_c; w++) begin push(inst, c, 4, r); c = c + 1; end
    end
    for (int d = 0; d < drain; d++) begin push(inst, c, 5, 0); c = c + 1; end
    push(inst, c, 6, 0);
  endtask

  task automatic mon(input int inst, input logic ld, input logic ac, input logic sk,
                     input logic mc, input logic sh, input logic dr, input logic dn,
                     input int sidx, input int stp);
    int n, code, idx, got, exp, have;
    n = int'(ld) + int'(sk) + int'(mc) + int'(sh) + int'(dr) + int'(dn);
    if (n == 0 && ac == 1'b0) return;
    checks++;
    if (n != 1 || ac != ld) begin
      errors++;
      $display("FAIL strobe_excl u%0d cyc=%0d: %0d strobes, acc_clr=%0b load_en=%0b",
               inst, cyc - base[inst], n, ac, ld);
    end
    code = ld ? 1 : sk ? 2 : mc ? 3 : sh ? 4 : dr ? 5 : 6;
    idx  = sk ? sidx : (mc || sh) ? stp : 0;
    got  = enc(cyc - base[inst], code, idx);
    have = 0;
    exp  = -1;
    case (inst)
      0:       if (q0.size() > 0) begin exp = q0.pop_front(); have = 1; end
      1:       if (q1.size() > 0) begin exp = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1; end
    endcase
    checks++;
    if (have == 0 || got != exp) begin
      errors++;
      $display("FAIL event u%0d: got c%0d code=%0d idx=%0d, expected c%0d code=%0d idx=%0d",
               inst, got / 64, (got / 8) % 8, got % 8, exp / 64, (exp / 8) % 8, exp % 8);
    end
  endtask

  always @(negedge clk) if (mon_en) mon(0, ld0, ac0, sk0, mc0, sh0, dr0, dn0, int'(sidx0), int'(stp0));
  always @(negedge clk) if (mon_en) mon(1, ld1, ac1, sk1, mc1, sh1, dr1, dn1, int'(sidx1), int'(stp1));
  always @(negedge clk) if (mon_en) mon(2, ld2, ac2, sk2, mc2, sh2, dr2, dn2, int'(sidx2), int'(stp2));

  function automatic logic dn_of(input int inst);
    case (inst)
      0:       return dn0;
      1:       return dn1;
      default: return dn2;
    endcase
  endfunction

  function automatic logic ov_of(input int inst);
    case (inst)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic bsy_of(input int inst);
    case (inst)
      0:       return bsy0;
      1:       return bsy1;
      default: return bsy2;
    endcase
  endfunction

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic go(input int inst);
    base[inst] = cyc;
    case (inst)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic finish_run(input int inst, input int exp_done);
    int seen, at;
    seen = 0;
    at   = -1;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (dn_of(inst)) begin seen = 1; at = cyc - base[inst]; end
    end
    chk($sformatf("done_seen_u%0d", inst), 64'(seen), 64'd1);
    chk($sformatf("done_cycle_u%0d", inst), 64'(at), 64'(exp_done));
    @(negedge clk);
    chk($sformatf("out_valid_after_u%0d", inst), 64'(ov_of(inst)), 64'd1);
    chk($sformatf("busy_after_u%0d", inst), 64'(bsy_of(inst)), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    start0 = 0; pre0 = 0; abort0 = 0; ack0 = 1;
    start1 = 0; pre1 = 0; abort1 = 0;
    start2 = 0; pre2 = 0; abort2 = 0; ack2 = 1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_u0_outputs", 64'({ld0, ac0, sk0, sidx0, mc0, sh0, dr0, stp0, bsy0, dn0, ov0, st0}), 64'd0);
    chk("reset_u1_state", 64'({st1, sidx1, stp1, ov1}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Default run with skew, then a back-to-back pre-skewed run.
    pre0 = 0; push_run(0, 2, 1, 4, 1, 2); go(0); finish_run(0, 14);
    pre0 = 1; push_run(0, 2, 0, 4, 1, 2); go(0); finish_run(0, 13);

    // Abort in the second MAC cycle.
    pre0 = 0;
    push(0, 1, 1, 0); push(0, 2, 2, 0); push(0, 3, 3, 0); push(0, 4, 3, 0);
    go(0);
    repeat (3) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_state", 64'(st0), 64'd0);
    chk("abort_busy", 64'(bsy0), 64'd0);
    chk("abort_out_valid", 64'(ov0), 64'd0);
    repeat (4) @(negedge clk);
    push_run(0, 2, 1, 4, 1, 2); go(0); finish_run(0, 14);

    // Abort during the DONE cycle still completes the run.
    pre0 = 1; push_run(0, 2, 0, 4, 1, 2); go(0);
    repeat (12) @(negedge clk);
    chk("done_pulse_c13", 64'(dn0), 64'd1);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_done_out_valid", 64'(ov0), 64'd1);
    chk("abort_done_state", 64'(st0), 64'd0);

    // Start while busy is ignored; reset mid-SHIFT clears everything.
    pre0 = 0; ack0 = 1'b0;
    push(0, 1, 1, 0); push(0, 2, 2, 0);
    for (int c = 3; c <= 6; c++) push(0, c, 3, 0);
    push(0, 7, 4, 0); push(0, 8, 4, 0);
    go(0);
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midshift_reset_outputs", 64'({ld0, ac0, sk0, sidx0, mc0, sh0, dr0, stp0, bsy0, dn0, ov0, st0}), 64'd0);
    rst = 1'b1; ack0 = 1'b1;
    @(negedge clk);

    // 4x4 grid, MAC_LAT=3, shifts acknowledged after 3 cycles.
    push_run(1, 4, 1, 3, 3, 2); go(1); finish_run(1, 28);

    // 1x1 grid without drain.
    push_run(2, 1, 1, 4, 1, 0); go(2); finish_run(2, 6);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cannon_sequencer.md
# cannon_sequencer

Parametrised control sequencer for the Cannon-algorithm block-matrix multiplier. It drives the processing-element (PE) grid through one multiply: operand load, optional initial skew, `SQRT_P` rounds of multiply-accumulate and operand shift, then drain. It starts on a `start` request, waits on a shift acknowledge from the grid, supports abort, and reports completion with a `done` pulse and a sticky `out_valid`. It replaces the fixed-length controller with configurable grid size, phase lengths and a pre-skewed input mode.

## Interface
- `SQRT_P`, 2: PE grid dimension; ≥1; equals shift rounds and step count.
- `MAC_LAT`, 4: cycles `mac_en` is held per step; ≥1.
- `DRAIN_LAT`, 2: cycles of `drain_en` before completion; 0 skips DRAIN.
- `IDXW`, derived: max(1, $clog2(SQRT_P)); not overridden.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; clock `clk`.
- `start`  in  1  run request; sampled only in IDLE.
- `preskewed`  in  1  latched with accepted `start`; 1 = operands already aligned, skip SKEW.
- `abort`  in  1  cancel run; ignored in IDLE.
- `shift_ack`  in  1  grid has completed the requested shift.
- `load_en`  out  1  one-cycle operand load strobe.
- `acc_clr`  out  1  accumulator clear; asserted together with `load_en`.
- `skew_en`  out  1  initial-alignment shift strobe.
- `skew_idx`  out  IDXW  skew pulse index; PE row/column k shifts only while `skew_idx` < k.
- `mac_en`  out  1  accumulate enable.
- `shift_en`  out  1  shift request; held until acknowledged.
- `drain_en`  out  1  result drain enable.
- `step`  out  IDXW  current MAC round, 0..SQRT_P-1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `out_valid`  out  1  result valid; sticky.
- `state`  out  3  debug encoding: IDLE=0, LOAD=1, SKEW=2, MAC=3, SHIFT=4, DRAIN=5, DONE=6.

## Operation
- Reset (`reset`=0 at an edge): state IDLE. All outputs 0, including `out_valid`, `step` and `skew_idx`. All counters cleared.
- Priority each edge: reset, then abort, then normal transitions.
- IDLE: `start`=1 → LOAD. `preskewed` is latched and `out_valid` is cleared on the same edge.
- LOAD: one cycle with `load_en`=`acc_clr`=1; `step`←0.
  - Next state is SKEW if latched `preskewed`=0 and SQRT_P>1; otherwise MAC.
- SKEW: SQRT_P-1 consecutive cycles with `skew_en`=1 and `skew_idx`=0,1,…,SQRT_P-2. Then MAC.
- MAC: `mac_en`=1 for exactly MAC_LAT cycles.
  - After the last cycle: if `step`=SQRT_P-1, go to DRAIN (or DONE when DRAIN_LAT=0); otherwise go to SHIFT.
- SHIFT: `shift_en`=1 every cycle until `shift_ack`=1 in the same cycle.
  - That edge: `step`←`step`+1 → MAC.
  - `shift_ack` outside SHIFT is ignored.
- DRAIN: `drain_en`=1 for DRAIN_LAT cycles → DONE.
- DONE: one cycle with `done`=1; `out_valid`←1 → IDLE. `out_valid` stays 1 until the next accepted `start`.
- `start` while `busy` is ignored and not queued.
- Abort in any non-IDLE state: go to IDLE next edge. Strobes drop, no `done`, `out_valid` stays 0, counters cleared.
- Abort in the DONE cycle: `done` still pulses and `out_valid` is set, because the run has already completed.
- Strobes are mutually exclusive except the pair `load_en`/`acc_clr`.
- Counter arithmetic is unsigned, with no wrap within legal parameters. The MAC counter is $clog2(MAC_LAT+1) bits.

## Timing
- `start` is sampled at edge E0; LOAD occupies cycle 1.
- `done` is high in cycle 2 + S + SQRT_P·MAC_LAT + ΣW + DRAIN_LAT, where:
  - S = SQRT_P-1 skew cycles, or 0 if pre-skewed or SQRT_P=1;
  - ΣW = total SHIFT cycles over SQRT_P-1 shifts, each ≥1.
- Defaults, immediate ack: LOAD c1, SKEW c2, MAC c3–6, SHIFT c7, MAC c8–11, DRAIN c12–13, DONE c14.
- All outputs are registered or decoded from registered state, with no combinational path from inputs. `shift_en` therefore drops on the edge after ack.
- Back-to-back runs: `start` sampled in the IDLE cycle after DONE → LOAD on the next cycle.

## Test plan
- Defaults, `preskewed`=0, `shift_ack` tied 1, `start` at E0 → `load_en` c1, `skew_en` c2 (`skew_idx`=0), `mac_en` c3–6/c8–11, `shift_en` c7, `done` c14, `out_valid`=1 from c15.
- Defaults, `preskewed`=1 → no `skew_en`; `done` at c13.
- SQRT_P=4, MAC_LAT=3, `shift_ack` delayed 2 cycles per shift → `skew_idx` 0,1,2; `step` 0..3; each SHIFT lasts 3 cycles; `done` at c2+3+12+9+2=c28.
- `abort` in second MAC cycle → IDLE next cycle, `busy`=0, no `done`, `out_valid`=0. A new `start` then completes normally.
- `start` pulsed while busy and `reset`=0 in mid-SHIFT → the pulse is ignored; after reset all outputs are 0 and the state is IDLE.
- SQRT_P=1, DRAIN_LAT=0 → LOAD c1, MAC c2–5, `done` c6, no `skew_en`/`shift_en`/`drain_en`.
